// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared constants and helpers for the speed-select button block
package button_pkg;

    localparam int NUM_BUTTONS = 5;

    typedef logic [NUM_BUTTONS-1:0] btn_vec_t;

    localparam btn_vec_t SEL_DEFAULT = 5'b00001;

    // Isolates the lowest set bit; bit 0 wins ties, zero in gives zero out.
    function automatic btn_vec_t lowest_onehot(input btn_vec_t v);
        return v & ((~v) + btn_vec_t'(1));
    endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - one-bit synchronizer, debounce counter, level and press pulse
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    // Press is registered alongside level so it marks the first high cycle.
                    level <= sync2;
                    press <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/button_speed_select.sv
// rtl/button_speed_select.sv - debounced five-button one-hot speed selector
module button_speed_select
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit LATCH_SEL       = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] buttons
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .press (btn_press[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buttons <= LATCH_SEL ? SEL_DEFAULT : '0;
        end else if (LATCH_SEL) begin
            // Sticky: only a fresh press moves the selection.
            if (|btn_press) begin
                buttons <= lowest_onehot(btn_press);
            end
        end else begin
            buttons <= lowest_onehot(btn_level);
        end
    end

endmodule

// File: tb/tb_button_speed_select.sv
// tb/tb_button_speed_select.sv - directed bench for button_speed_select at DEBOUNCE_CYCLES=4
module tb_button_speed_select;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn_raw = '0;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [4:0] buttons;
    logic [4:0] btn_raw0 = '0;
    logic [4:0] btn_level0;
    logic [4:0] btn_press0;
    logic [4:0] buttons0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    button_speed_select #(.DEBOUNCE_CYCLES(4), .LATCH_SEL(1)) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .buttons(buttons)
    );

    button_speed_select #(.DEBOUNCE_CYCLES(4), .LATCH_SEL(0)) dut_mom (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw0),
        .btn_level(btn_level0), .btn_press(btn_press0), .buttons(buttons0)
    );

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        btn_raw = '0;
        btn_raw0 = '0;
        tick(2);
        rst_n = 1'b1;
        total++;
        if (buttons !== 5'b00001) begin
            bad++; $display("FAIL reset_buttons got=%b want=%b", buttons, 5'b00001);
        end
        total++;
        if (btn_level !== 5'b00000 || btn_press !== 5'b00000) begin
            bad++; $display("FAIL reset_level_press got=%b/%b want=00000/00000", btn_level, btn_press);
        end
        total++;
        if (buttons0 !== 5'b00000) begin
            bad++; $display("FAIL reset_buttons_mom got=%b want=%b", buttons0, 5'b00000);
        end
    endtask

    task automatic test_glitch;
        logic [4:0] seen_level;
        logic [4:0] seen_press;
        seen_level = '0;
        seen_press = '0;
        btn_raw = 5'b10000;
        tick(3);
        btn_raw = '0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            seen_level |= btn_level;
            seen_press |= btn_press;
        end
        total++;
        if (seen_level !== 5'b00000 || seen_press !== 5'b00000) begin
            bad++; $display("FAIL glitch_level_press got=%b/%b want=00000/00000", seen_level, seen_press);
        end
        total++;
        if (buttons !== 5'b00001) begin
            bad++; $display("FAIL glitch_buttons got=%b want=%b", buttons, 5'b00001);
        end
    endtask

    task automatic test_clean_press;
        int presses;
        btn_raw = 5'b00100;
        tick(5);
        total++;
        if (btn_level !== 5'b00000) begin
            bad++; $display("FAIL clean_level_early got=%b want=%b", btn_level, 5'b00000);
        end
        tick(1);
        total++;
        if (btn_level !== 5'b00100 || btn_press !== 5'b00100) begin
            bad++; $display("FAIL clean_level_press got=%b/%b want=00100/00100", btn_level, btn_press);
        end
        total++;
        if (buttons !== 5'b00001) begin
            bad++; $display("FAIL clean_buttons_same_cycle got=%b want=%b", buttons, 5'b00001);
        end
        tick(1);
        total++;
        if (btn_press !== 5'b00000 || buttons !== 5'b00100) begin
            bad++; $display("FAIL clean_after got=press %b buttons %b want=00000/00100", btn_press, buttons);
        end
        presses = 0;
        for (int k = 0; k < 13; k++) begin
            tick(1);
            if (btn_press != 5'b00000) presses++;
        end
        btn_raw = '0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            if (btn_press != 5'b00000) presses++;
        end
        total++;
        if (presses != 0 || btn_level !== 5'b00000 || buttons !== 5'b00100) begin
            bad++; $display("FAIL clean_hold_release got=presses %0d level %b buttons %b want=0/00000/00100",
                            presses, btn_level, buttons);
        end
    endtask

    task automatic test_simultaneous;
        btn_raw = 5'b11000;
        tick(6);
        total++;
        if (btn_press !== 5'b11000) begin
            bad++; $display("FAIL simul_press got=%b want=%b", btn_press, 5'b11000);
        end
        tick(1);
        total++;
        if (buttons !== 5'b01000 || btn_press !== 5'b00000) begin
            bad++; $display("FAIL simul_buttons got=%b press %b want=01000/00000", buttons, btn_press);
        end
        btn_raw = '0;
        tick(8);
    endtask

    task automatic test_bounce;
        int presses;
        presses = 0;
        for (int k = 0; k < 10; k++) begin
            btn_raw = ((k / 2) % 2 == 0) ? 5'b00010 : 5'b00000;
            tick(1);
            if (btn_press[1]) presses++;
        end
        btn_raw = 5'b00010;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (btn_press[1]) presses++;
        end
        total++;
        if (presses != 1) begin
            bad++; $display("FAIL bounce_pulses got=%0d want=1", presses);
        end
        total++;
        if (buttons !== 5'b00010) begin
            bad++; $display("FAIL bounce_buttons got=%b want=%b", buttons, 5'b00010);
        end
        btn_raw = '0;
        tick(8);
    endtask

    task automatic test_repress_same;
        int presses;
        presses = 0;
        btn_raw = 5'b00010;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (btn_press[1]) presses++;
        end
        total++;
        if (presses != 1 || buttons !== 5'b00010) begin
            bad++; $display("FAIL repress_same got=presses %0d buttons %b want=1/00010", presses, buttons);
        end
        btn_raw = '0;
        tick(8);
    endtask

    task automatic test_reset_mid;
        btn_raw = 5'b10000;
        tick(8);
        total++;
        if (buttons !== 5'b10000) begin
            bad++; $display("FAIL mid_select got=%b want=%b", buttons, 5'b10000);
        end
        btn_raw = '0;
        tick(8);
        btn_raw = 5'b01000;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        total++;
        if (buttons !== 5'b00001 || btn_level !== 5'b00000) begin
            bad++; $display("FAIL mid_reset got=buttons %b level %b want=00001/00000", buttons, btn_level);
        end
        tick(5);
        total++;
        if (btn_press !== 5'b00000) begin
            bad++; $display("FAIL mid_press_early got=%b want=%b", btn_press, 5'b00000);
        end
        tick(1);
        total++;
        if (btn_press !== 5'b01000) begin
            bad++; $display("FAIL mid_press got=%b want=%b", btn_press, 5'b01000);
        end
        tick(1);
        total++;
        if (buttons !== 5'b01000) begin
            bad++; $display("FAIL mid_buttons got=%b want=%b", buttons, 5'b01000);
        end
        btn_raw = '0;
        tick(8);
    endtask

    task automatic test_momentary;
        btn_raw0 = 5'b00001;
        tick(6);
        total++;
        if (btn_level0 !== 5'b00001 || buttons0 !== 5'b00000) begin
            bad++; $display("FAIL mom_level got=level %b buttons %b want=00001/00000", btn_level0, buttons0);
        end
        tick(1);
        total++;
        if (buttons0 !== 5'b00001) begin
            bad++; $display("FAIL mom_held got=%b want=%b", buttons0, 5'b00001);
        end
        tick(3);
        btn_raw0 = '0;
        tick(6);
        total++;
        if (btn_level0 !== 5'b00000 || buttons0 !== 5'b00001) begin
            bad++; $display("FAIL mom_fall got=level %b buttons %b want=00000/00001", btn_level0, buttons0);
        end
        tick(1);
        total++;
        if (buttons0 !== 5'b00000) begin
            bad++; $display("FAIL mom_release got=%b want=%b", buttons0, 5'b00000);
        end
        btn_raw0 = 5'b10100;
        tick(7);
        total++;
        if (buttons0 !== 5'b00100) begin
            bad++; $display("FAIL mom_priority got=%b want=%b", buttons0, 5'b00100);
        end
        btn_raw0 = '0;
        tick(8);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_clean_press();
        test_simultaneous();
        test_bounce();
        test_repress_same();
        test_reset_mid();
        test_momentary();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_speed_select.md
BUTTON_SPEED_SELECT -- requirements
Module: button_speed_select

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz), the number of consecutive stable cycles required to accept a level change; legal range >= 2.
REQ-002 SHALL have parameter LATCH_SEL, default 1; 1 = sticky selection, 0 = momentary selection.
REQ-003 SHALL have port clk, input, 1, 50 MHz system clock.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port btn_raw, input, 5, raw asynchronous push-buttons, active-high.
REQ-006 SHALL have port btn_level, output, 5, debounced button levels.
REQ-007 SHALL have port btn_press, output, 5, one-cycle rising-edge pulse per debounced button.
REQ-008 SHALL have port buttons, output, 5, one-hot speed selection feeding the LED cycle block's buttons input.

Function
REQ-009 SHALL pass each btn_raw bit through a 2-flop synchronizer before any other use.
REQ-010 SHALL keep a per-button counter of width max(1, clog2(DEBOUNCE_CYCLES)): if synced != btn_level, the counter increments; at DEBOUNCE_CYCLES-1 it instead sets btn_level to synced and clears; if synced == btn_level, it clears.
REQ-011 SHALL make btn_level change exactly 2+DEBOUNCE_CYCLES cycles after btn_raw settles at a new value; any glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL leave btn_level unchanged.
REQ-012 SHALL assert btn_press[i] for exactly one cycle, the first cycle btn_level[i] is 1; a release SHALL generate no pulse.
REQ-013 with LATCH_SEL=1, SHALL register buttons to the one-hot of the lowest-index set bit of btn_press, one cycle after the pulse; the value SHALL be held when no press occurs.
REQ-014 with LATCH_SEL=1, simultaneous presses SHALL resolve to the lowest index (bit 0 highest priority); re-pressing the current button SHALL leave buttons unchanged.
REQ-015 with LATCH_SEL=0, SHALL register buttons to the one-hot of the lowest-index set bit of btn_level, one cycle after the level changes; buttons SHALL be 5'b00000 when no button is held.
REQ-016 SHALL make buttons always zero- or one-hot; it SHALL never have more than one bit set.
REQ-017 SHALL keep holding a button from producing repeated btn_press pulses; a new pulse requires a debounced release then a press.

Reset
REQ-018 on rst_n=0 at a clk edge, SHALL clear synchronizer flops, counters, btn_level and btn_press to 0.
REQ-019 on reset, SHALL set buttons to 5'b00001 when LATCH_SEL=1 (slowest speed) and to 5'b00000 when LATCH_SEL=0.
REQ-020 SHALL let reset mid-debounce discard partial counts; a button held through reset release SHALL produce a btn_press 2+DEBOUNCE_CYCLES cycles after rst_n rises.

Structure
REQ-021 SHALL place NUM_BUTTONS=5 and the reset selection constant SEL_DEFAULT=5'b00001 in shared package button_pkg.
REQ-022 SHALL implement the synchronizer, counter, level and edge pulse for one bit as sub-module button_debounce, instantiated 5 times via generate.
REQ-023 SHALL keep the priority encode and selection register in button_speed_select; no clocks derived from logic.

Verification (DEBOUNCE_CYCLES=4)
REQ-024 Clean press: btn_raw[2] 0->1 held 20 cycles -> btn_level[2]=1 after 6 cycles, btn_press=5'b00100 for 1 cycle, buttons=5'b00100 one cycle later.
REQ-025 Glitch: btn_raw[4] high for 3 cycles, then low -> btn_level, btn_press and buttons unchanged (5'b00001).
REQ-026 Simultaneous: btn_raw=5'b11000 on the same cycle -> btn_press=5'b11000 for 1 cycle, buttons=5'b01000.
REQ-027 Bounce: btn_raw[1] toggles every 2 cycles for 10 cycles, then high -> exactly one btn_press[1] pulse, buttons=5'b00010.
REQ-028 Reset mid-operation: select 5'b10000, assert rst_n=0 for 1 cycle with btn_raw[3] held -> buttons=5'b00001 next cycle, then 5'b01000 seven cycles after rst_n rises.
REQ-029 LATCH_SEL=0: hold btn_raw[0] 10 cycles, release -> buttons=5'b00001 while btn_level[0]=1, 5'b00000 one cycle after btn_level[0] falls.
